// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage next-PC sequencer: FSM state
// encodings, default parameter values and the sequential PC adder.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_seq_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0080;
  localparam int unsigned PC_INC_DEF       = 4;
  localparam int unsigned CNT_W_DEF        = 16;

  // Sequential next PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_add(input logic [31:0] pc, input int unsigned inc);
    return pc + 32'(inc);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between ID/hazard logic, the PC register and the next-PC sequencer.
// Optional trap pins are present only when PC_SEQ_TRAP_EN is defined.
interface pc_sequencer_if import pc_sequencer_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic              start_i;
  logic              hd_i;
  logic              imem_ready_i;
  logic [31:0]       pc_i;
  logic              branch_i;
  logic [31:0]       branch_target_i;
  logic              jump_i;
  logic [31:0]       jump_target_i;
  logic [31:0]       pc_next_o;
  logic              pc_write_o;
  logic              if_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o;
`ifdef PC_SEQ_TRAP_EN
  logic              trap_i;
  logic [31:0]       epc_o;

  modport slave (
    input  start_i, hd_i, imem_ready_i, pc_i, branch_i, branch_target_i,
           jump_i, jump_target_i, trap_i,
    output pc_next_o, pc_write_o, if_flush_o, stall_cnt_o, epc_o
  );

  modport master (
    output start_i, hd_i, imem_ready_i, pc_i, branch_i, branch_target_i,
           jump_i, jump_target_i, trap_i,
    input  pc_next_o, pc_write_o, if_flush_o, stall_cnt_o, epc_o
  );
`else
  modport slave (
    input  start_i, hd_i, imem_ready_i, pc_i, branch_i, branch_target_i,
           jump_i, jump_target_i,
    output pc_next_o, pc_write_o, if_flush_o, stall_cnt_o
  );

  modport master (
    output start_i, hd_i, imem_ready_i, pc_i, branch_i, branch_target_i,
           jump_i, jump_target_i,
    input  pc_next_o, pc_write_o, if_flush_o, stall_cnt_o
  );
`endif

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect buffer: holds a branch/jump target that arrived
// while instruction memory was not ready, until the sequencer applies it.
module pc_redirect_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] target_i,
  output logic        pend_v_o,
  output logic [31:0] target_o
);

  logic        pend_v_q;
  logic [31:0] target_q;

  // Valid flag: clear wins so an applied or trapped-over redirect never lingers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_v_q <= 1'b0;
    end else if (clear_i) begin
      pend_v_q <= 1'b0;
    end else if (load_i) begin
      pend_v_q <= 1'b1;
    end
  end

  // Target payload is only meaningful while pend_v_q is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (load_i && !clear_i) begin
      target_q <= target_i;
    end
  end

  assign pend_v_o = pend_v_q;
  assign target_o = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer for the fetch stage: IDLE/RUN/PEND FSM, next-PC mux
// (trap > pending target > jump > branch > PC+PC_INC), PC write gating,
// IF/ID flush and a saturating stall counter.
// Optional trap redirect and EPC capture are built when PC_SEQ_TRAP_EN is defined.
module pc_sequencer import pc_sequencer_pkg::*; #(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int unsigned PC_INC       = PC_INC_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pc_sequencer_if.slave bus
);

  pc_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             active;
  logic             trap_act;
  logic             pend_v;
  logic [31:0]      pend_tgt;
  logic             redir_req;
  logic [31:0]      redir_tgt;
  logic             pend_load;
  logic             pend_apply;
  logic             pend_clear;
  logic             pc_write;
  logic [31:0]      pc_next;
  logic             if_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign active = (state_q != ST_IDLE);

`ifdef PC_SEQ_TRAP_EN
  logic [31:0] epc_q;

  assign trap_act = active & bus.trap_i;

  // Faulting PC is captured on the trap cycle; it is data only, so no reset.
  always_ff @(posedge clk_i) begin
    if (trap_act) begin
      epc_q <= bus.pc_i;
    end
  end

  assign bus.epc_o = epc_q;
`else
  assign trap_act = 1'b0;
`endif

  // A new redirect is only taken when ID is not stalled and nothing is already buffered.
  assign redir_req  = active & ~bus.hd_i & ~pend_v & (bus.branch_i | bus.jump_i);
  assign redir_tgt  = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
  assign pc_write   = trap_act | (active & bus.imem_ready_i & ~bus.hd_i);
  assign pend_load  = redir_req & ~bus.imem_ready_i & ~trap_act;
  assign pend_apply = active & pend_v & bus.imem_ready_i & ~bus.hd_i;
  assign pend_clear = trap_act | pend_apply;

  pc_redirect_buf u_redirect_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (pend_load),
    .clear_i  (pend_clear),
    .target_i (redir_tgt),
    .pend_v_o (pend_v),
    .target_o (pend_tgt)
  );

  // Next-PC mux and flush; flush follows the write enable whenever a redirect is selected.
  always_comb begin
    pc_next  = RESET_VECTOR;
    if_flush = 1'b0;
    if (trap_act) begin
      pc_next  = TRAP_VECTOR;
      if_flush = 1'b1;
    end else if (active) begin
      if (pend_v) begin
        pc_next  = pend_tgt;
        if_flush = pc_write;
      end else if (redir_req) begin
        pc_next  = redir_tgt;
        if_flush = pc_write;
      end else begin
        pc_next  = pc_add(bus.pc_i, PC_INC);
      end
    end
  end

  // Next-state: start_i=0 always parks in IDLE; a retained redirect resumes via PEND.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start_i) state_d = pend_v ? ST_PEND : ST_RUN;
      ST_RUN: begin
        if (!bus.start_i)  state_d = ST_IDLE;
        else if (pend_load) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!bus.start_i)  state_d = ST_IDLE;
        else if (pend_clear) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall counter: every active cycle without a PC write, held at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (active && !pc_write) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign bus.pc_next_o   = pc_next;
  assign bus.pc_write_o  = pc_write;
  assign bus.if_flush_o  = if_flush;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (CNT_W=4 so saturation is reachable).
module tb_pc_sequencer;

  localparam int unsigned CW = 4;

  logic clk_i;
  logic rst_i;
  int   n_cmp;
  int   n_err;

  pc_sequencer_if #(.CNT_W(CW)) bus ();

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0080),
    .PC_INC       (4),
    .CNT_W        (CW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] nxt, input logic wr, input logic fl);
    chk({tag, ".pc_next"}, bus.pc_next_o, nxt);
    chk({tag, ".pc_write"}, {31'd0, bus.pc_write_o}, {31'd0, wr});
    chk({tag, ".if_flush"}, {31'd0, bus.if_flush_o}, {31'd0, fl});
  endtask

  task automatic clr_redir();
    bus.branch_i = 1'b0;
    bus.jump_i   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_i = 1'b0;
    bus.start_i         = 1'b0;
    bus.hd_i            = 1'b0;
    bus.imem_ready_i    = 1'b0;
    bus.pc_i            = 32'h0000_0100;
    bus.branch_i        = 1'b0;
    bus.branch_target_i = 32'h0;
    bus.jump_i          = 1'b0;
    bus.jump_target_i   = 32'h0;
`ifdef PC_SEQ_TRAP_EN
    bus.trap_i          = 1'b0;
`endif
    tick();
    tick();
    #1;
    chk_out("reset", 32'h0, 1'b0, 1'b0);
    chk("reset.stall", {28'd0, bus.stall_cnt_o}, 32'd0);
    rst_i = 1'b1;

    // 1: start, IDLE cycle then sequential fetch
    bus.start_i      = 1'b1;
    bus.imem_ready_i = 1'b1;
    #1;
    chk_out("idle_start", 32'h0, 1'b0, 1'b0);
    tick();
    #1;
    chk_out("seq", 32'h104, 1'b1, 1'b0);
    chk("seq.stall", {28'd0, bus.stall_cnt_o}, 32'd0);

    // 2: hazard stall 3 cycles, branch ignored
    bus.hd_i            = 1'b1;
    bus.branch_i        = 1'b1;
    bus.branch_target_i = 32'h200;
    #1;
    chk_out("hd", 32'h104, 1'b0, 1'b0);
    tick();
    chk("hd.stall1", {28'd0, bus.stall_cnt_o}, 32'd1);
    tick();
    tick();
    chk("hd.stall3", {28'd0, bus.stall_cnt_o}, 32'd3);
    bus.hd_i = 1'b0;

    // 3: branch with memory not ready -> PEND, then applied
    bus.imem_ready_i = 1'b0;
    #1;
    chk("pend_cap.write", {31'd0, bus.pc_write_o}, 32'd0);
    chk("pend_cap.flush", {31'd0, bus.if_flush_o}, 32'd0);
    tick();
    chk("pend.stall4", {28'd0, bus.stall_cnt_o}, 32'd4);
    #1;
    chk("pend_wait.write", {31'd0, bus.pc_write_o}, 32'd0);
    tick();
    chk("pend.stall5", {28'd0, bus.stall_cnt_o}, 32'd5);
    bus.branch_i      = 1'b0;
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h300;
    bus.imem_ready_i  = 1'b1;
    #1;
    chk_out("pend_apply", 32'h200, 1'b1, 1'b1);
    tick();
    clr_redir();
    #1;
    chk_out("after_apply", 32'h104, 1'b1, 1'b0);
    chk("after_apply.stall", {28'd0, bus.stall_cnt_o}, 32'd5);

    // 4: jump beats branch; PC wrap
    bus.jump_i        = 1'b1;
    bus.jump_target_i = 32'h300;
    bus.branch_i      = 1'b1;
    bus.branch_target_i = 32'h200;
    #1;
    chk_out("jump_prio", 32'h300, 1'b1, 1'b1);
    tick();
    clr_redir();
    bus.pc_i = 32'hFFFF_FFFC;
    #1;
    chk_out("wrap", 32'h0, 1'b1, 1'b0);

    // stall counter saturation (5 + 12 > 15)
    bus.pc_i = 32'h100;
    bus.hd_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("stall_sat", {28'd0, bus.stall_cnt_o}, 32'd15);
    bus.hd_i = 1'b0;

    // start_i=0 parks in IDLE
    bus.start_i = 1'b0;
    tick();
    #1;
    chk_out("stop_idle", 32'h0, 1'b0, 1'b0);

    // pending redirect survives IDLE and resumes through PEND
    bus.start_i = 1'b1;
    tick();
    bus.branch_i        = 1'b1;
    bus.branch_target_i = 32'h280;
    bus.imem_ready_i    = 1'b0;
    tick();
    clr_redir();
    bus.start_i = 1'b0;
    tick();
    #1;
    chk_out("pend_idle", 32'h0, 1'b0, 1'b0);
    bus.start_i = 1'b1;
    tick();
    bus.imem_ready_i = 1'b1;
    #1;
    chk_out("pend_resume", 32'h280, 1'b1, 1'b1);
    tick();

    // 5: reset during PEND clears the buffered redirect
    bus.branch_i        = 1'b1;
    bus.branch_target_i = 32'h240;
    bus.imem_ready_i    = 1'b0;
    tick();
    clr_redir();
    rst_i = 1'b0;
    #1;
    chk_out("rst_pend", 32'h0, 1'b0, 1'b0);
    chk("rst_pend.stall", {28'd0, bus.stall_cnt_o}, 32'd0);
    tick();
    rst_i = 1'b1;
    bus.imem_ready_i = 1'b1;
    #1;
    chk_out("rst_idle", 32'h0, 1'b0, 1'b0);
    tick();
    #1;
    chk_out("no_stale", 32'h104, 1'b1, 1'b0);

`ifdef PC_SEQ_TRAP_EN
    // 6: trap overrides hazard stall; EPC captured
    bus.hd_i   = 1'b1;
    bus.pc_i   = 32'h40;
    bus.trap_i = 1'b1;
    #1;
    chk_out("trap", 32'h80, 1'b1, 1'b1);
    tick();
    bus.trap_i = 1'b0;
    bus.hd_i   = 1'b0;
    chk("trap.epc", bus.epc_o, 32'h40);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
